// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned UART_NUM_REQ_MAX = 8;
  localparam int unsigned UART_STATE_W     = 2;

  typedef enum logic [UART_STATE_W-1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } uart_arb_state_t;

  // Index width for n requesters, at least one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: searches from last+1 upward, wrapping.
module rr_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] last,
  output logic            valid,
  output logic [IDXW-1:0] idx
);

  int unsigned base;
  int unsigned cand;

  // First set request after last, in rotating order.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    base  = 32'(last);
    cand  = 0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = (base + off) % N;
      if (!valid && req[IDXW'(cand)]) begin
        valid = 1'b1;
        idx   = IDXW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx between several byte producers.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned BUSY_TIMEOUT = 16,
  parameter int unsigned GAP_CYCLES   = 0
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [8*NUM_REQ-1:0]               req_data,
  output logic [NUM_REQ-1:0]                 ack,
  output logic                               tx_start,
  output logic [7:0]                         tx_data,
  input  logic                               tx_busy,
  output logic [idx_width(NUM_REQ)-1:0]      grant_id,
  output logic                               active,
  output logic                               err_timeout
);

  localparam int unsigned IDXW    = idx_width(NUM_REQ);
  localparam int unsigned CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [IDXW-1:0]  LAST_RST  = IDXW'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;
  localparam uart_arb_state_t  AFTER_BYTE = (GAP_CYCLES == 0) ? IDLE : GAP;

  uart_arb_state_t    state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDXW-1:0]    last_q, last_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               tx_start_d;
  logic [7:0]         tx_data_d;
  logic [IDXW-1:0]    grant_d;
  logic               err_d;

  logic               pick_valid;
  logic [IDXW-1:0]    pick_idx;
  logic [7:0]         win_data;
  logic [NUM_REQ-1:0] win_onehot;

  rr_pick #(
    .N    (NUM_REQ),
    .IDXW (IDXW)
  ) u_rr_pick (
    .req   (req),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Winner's byte and one-hot ack mask.
  always_comb begin
    win_data   = 8'h00;
    win_onehot = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDXW'(i)) begin
        win_data      = req_data[8*i +: 8];
        win_onehot[i] = 1'b1;
      end
    end
  end

  // Saturating counter step shared by timeout and gap phases.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next-state and next-output logic for the byte sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    grant_d    = grant_id;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid && !tx_busy) begin
          ack_d      = win_onehot;
          tx_start_d = 1'b1;
          tx_data_d  = win_data;
          grant_d    = pick_idx;
          last_d     = pick_idx;
          cnt_d      = '0;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == BUSY_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = AFTER_BYTE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          cnt_d   = '0;
          state_d = AFTER_BYTE;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= LAST_RST;
      ack         <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      grant_id    <= '0;
      active      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ack         <= ack_d;
      tx_start    <= tx_start_d;
      tx_data     <= tx_data_d;
      grant_id    <= grant_d;
      active      <= (state_d != IDLE);
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: cycle table on a 3-requester arbiter, hand sequences on a gapped one.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Arbiter A: 3 requesters, short timeout, no gap.
  logic        a_rst;
  logic [2:0]  a_req;
  logic [23:0] a_data;
  logic [2:0]  a_ack;
  logic        a_start;
  logic [7:0]  a_txd;
  logic        a_busy;
  logic [1:0]  a_gid;
  logic        a_act;
  logic        a_err;

  uart_tx_arbiter #(
    .NUM_REQ      (3),
    .BUSY_TIMEOUT (4),
    .GAP_CYCLES   (0)
  ) dut_a (
    .sys_clk     (clk),
    .sys_rst     (a_rst),
    .req         (a_req),
    .req_data    (a_data),
    .ack         (a_ack),
    .tx_start    (a_start),
    .tx_data     (a_txd),
    .tx_busy     (a_busy),
    .grant_id    (a_gid),
    .active      (a_act),
    .err_timeout (a_err)
  );

  // Arbiter G: 2 requesters, default timeout, 5-cycle gap.
  logic        g_rst;
  logic [1:0]  g_req;
  logic [15:0] g_data;
  logic [1:0]  g_ack;
  logic        g_start;
  logic [7:0]  g_txd;
  logic        g_busy;
  logic [0:0]  g_gid;
  logic        g_act;
  logic        g_err;

  uart_tx_arbiter #(
    .NUM_REQ      (2),
    .BUSY_TIMEOUT (16),
    .GAP_CYCLES   (5)
  ) dut_g (
    .sys_clk     (clk),
    .sys_rst     (g_rst),
    .req         (g_req),
    .req_data    (g_data),
    .ack         (g_ack),
    .tx_start    (g_start),
    .tx_data     (g_txd),
    .tx_busy     (g_busy),
    .grant_id    (g_gid),
    .active      (g_act),
    .err_timeout (g_err)
  );

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [23:0] data;
    logic        busy;
    int          n;
    logic [2:0]  ack;
    logic        st;
    logic [7:0]  txd;
    logic [1:0]  gid;
    logic        act;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam logic [23:0] D = {8'h30, 8'h20, 8'h10};
  localparam logic [23:0] S = {8'h30, 8'h20, 8'h41};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  initial begin
    int k;
    a_rst = 1'b1; a_req = '0; a_data = '0; a_busy = 1'b0;
    g_rst = 1'b1; g_req = '0; g_data = '0; g_busy = 1'b0;

    //                rst   req     data busy n   ack    st    txd    gid  act   err
    vecs.push_back('{1'b1, 3'b000, D, 1'b0, 2,  3'b000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0}); // 0 reset
    vecs.push_back('{1'b0, 3'b001, S, 1'b0, 1,  3'b001, 1'b1, 8'h41, 2'd0, 1'b1, 1'b0}); // 1 single grant
    vecs.push_back('{1'b0, 3'b000, S, 1'b0, 2,  3'b000, 1'b0, 8'h41, 2'd0, 1'b1, 1'b0}); // 2
    vecs.push_back('{1'b0, 3'b000, S, 1'b1, 10, 3'b000, 1'b0, 8'h41, 2'd0, 1'b1, 1'b0}); // 3 busy 2..11
    vecs.push_back('{1'b0, 3'b000, S, 1'b0, 1,  3'b000, 1'b0, 8'h41, 2'd0, 1'b0, 1'b0}); // 4 active drops
    vecs.push_back('{1'b0, 3'b000, S, 1'b0, 1,  3'b000, 1'b0, 8'h41, 2'd0, 1'b0, 1'b0}); // 5
    vecs.push_back('{1'b1, 3'b000, D, 1'b0, 1,  3'b000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0}); // 6 reset
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0}); // 7 contention -> 0
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 8
    vecs.push_back('{1'b0, 3'b111, D, 1'b1, 2,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 9
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0}); // 10
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b010, 1'b1, 8'h20, 2'd1, 1'b1, 1'b0}); // 11 -> 1
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b000, 1'b0, 8'h20, 2'd1, 1'b1, 1'b0}); // 12
    vecs.push_back('{1'b0, 3'b111, D, 1'b1, 2,  3'b000, 1'b0, 8'h20, 2'd1, 1'b1, 1'b0}); // 13
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b000, 1'b0, 8'h20, 2'd1, 1'b0, 1'b0}); // 14
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b100, 1'b1, 8'h30, 2'd2, 1'b1, 1'b0}); // 15 -> 2
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b000, 1'b0, 8'h30, 2'd2, 1'b1, 1'b0}); // 16
    vecs.push_back('{1'b0, 3'b111, D, 1'b1, 2,  3'b000, 1'b0, 8'h30, 2'd2, 1'b1, 1'b0}); // 17
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b000, 1'b0, 8'h30, 2'd2, 1'b0, 1'b0}); // 18
    vecs.push_back('{1'b0, 3'b111, D, 1'b0, 1,  3'b001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0}); // 19 -> 0 again
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 20
    vecs.push_back('{1'b0, 3'b010, D, 1'b1, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 21 withdraw pulse
    vecs.push_back('{1'b0, 3'b000, D, 1'b1, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 22
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0}); // 23
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 2,  3'b000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0}); // 24 no ack[1]
    vecs.push_back('{1'b0, 3'b100, D, 1'b1, 2,  3'b000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b0}); // 25 busy blocks
    vecs.push_back('{1'b0, 3'b100, D, 1'b0, 1,  3'b100, 1'b1, 8'h30, 2'd2, 1'b1, 1'b0}); // 26 -> 2
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 3,  3'b000, 1'b0, 8'h30, 2'd2, 1'b1, 1'b0}); // 27 no busy
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 1,  3'b000, 1'b0, 8'h30, 2'd2, 1'b0, 1'b1}); // 28 timeout
    vecs.push_back('{1'b0, 3'b011, D, 1'b0, 1,  3'b001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0}); // 29 next served
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 30
    vecs.push_back('{1'b0, 3'b010, D, 1'b1, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 31 WAIT_DONE
    vecs.push_back('{1'b1, 3'b010, D, 1'b1, 1,  3'b000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0}); // 32 reset mid-byte
    vecs.push_back('{1'b0, 3'b011, D, 1'b1, 2,  3'b000, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0}); // 33 still busy
    vecs.push_back('{1'b0, 3'b011, D, 1'b0, 1,  3'b001, 1'b1, 8'h10, 2'd0, 1'b1, 1'b0}); // 34 req 0 first
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 3,  3'b000, 1'b0, 8'h10, 2'd0, 1'b1, 1'b0}); // 35
    vecs.push_back('{1'b0, 3'b000, D, 1'b0, 1,  3'b000, 1'b0, 8'h10, 2'd0, 1'b0, 1'b1}); // 36 timeout

    for (int v = 0; v < vecs.size(); v++) begin
      for (int r = 0; r < vecs[v].n; r++) begin
        a_rst  = vecs[v].rst;
        a_req  = vecs[v].req;
        a_data = vecs[v].data;
        a_busy = vecs[v].busy;
        tick();
        n_vec++;
        if (a_ack !== vecs[v].ack || a_start !== vecs[v].st || a_txd !== vecs[v].txd ||
            a_gid !== vecs[v].gid || a_act !== vecs[v].act || a_err !== vecs[v].err) begin
          n_bad++;
          $display("FAIL vec%0d.%0d: got ack=%b st=%b txd=%h gid=%0d act=%b err=%b, want ack=%b st=%b txd=%h gid=%0d act=%b err=%b",
                   v, r, a_ack, a_start, a_txd, a_gid, a_act, a_err,
                   vecs[v].ack, vecs[v].st, vecs[v].txd, vecs[v].gid, vecs[v].act, vecs[v].err);
        end
      end
    end

    // Gapped arbiter: back-to-back bytes from one requester.
    tick();
    chk("g_reset_active", 32'(g_act), 32'h0);
    g_rst = 1'b0;
    g_req = 2'b01;
    g_data = 16'h0055;
    tick();
    chk("g_start", 32'(g_start), 32'h1);
    chk("g_ack", 32'(g_ack), 32'h1);
    chk("g_txd0", 32'(g_txd), 32'h55);
    g_data = 16'h0066;
    tick();
    g_busy = 1'b1;
    repeat (3) tick();
    g_busy = 1'b0;
    tick();
    chk("g_active_after_fall", 32'(g_act), 32'h1);
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (k == 3) chk("g_active_in_gap", 32'(g_act), 32'h1);
      if (k == 5) chk("g_idle_before_grant", 32'(g_act), 32'h0);
      if (g_start) break;
    end
    chk("g_gap_spacing", 32'(k), 32'd6);
    chk("g_txd1", 32'(g_txd), 32'h66);
    chk("g_ack1", 32'(g_ack), 32'h1);

    // Gapped arbiter: timeout followed by gap then the next byte.
    g_data = 16'h0077;
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (g_err) break;
    end
    chk("g_timeout_at", 32'(k), 32'd16);
    k = 0;
    while (k < 40) begin
      tick();
      k++;
      if (g_start) break;
    end
    chk("g_after_timeout", 32'(k), 32'd6);
    chk("g_txd2", 32'(g_txd), 32'h77);
    g_req = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
